ssdisp_scan: RTL and testbench
==============================

# ssdisp_scan

Time-multiplexed scan controller that shares one `ssdec` seven-segment decoder across `NDIGITS` common-cathode digits. It holds a double-buffered display image (hex nibbles plus per-digit enable and blink masks) and steps one digit at a time. It drives the shared decoder and the digit-select lines, and swaps in newly loaded images only at frame boundaries so a frame never shows a mix of two images. It sits between the game logic, which writes scores and patterns, and the board's digit pins.

## Interface
- `NDIGITS`, 8: number of scanned digits (2..16).
- `DWELL`, 100: clock cycles each digit is held (≥2).
- `BLINK_FRAMES`, 25: full frames per blink half-period (≥1).

- `hz100`, in, 1: system clock.
- `reset`, in, 1: reset, asynchronous and active-high.
- `load`, in, 1: one-cycle strobe; captures `value`, `en_mask` and `blink_mask` into the pending buffer.
- `value`, in, 4*NDIGITS: nibble i selects the glyph for digit i.
- `en_mask`, in, NDIGITS: bit i=1 shows digit i; bit i=0 blanks it.
- `blink_mask`, in, NDIGITS: bit i=1 makes digit i blink.
- `seg`, out, 7: segment drive (gfedcba), registered.
- `an`, out, NDIGITS: one-hot digit select, registered.
- `pending`, out, 1: a loaded image is waiting for the next frame boundary.
- `frame_start`, out, 1: one-cycle pulse, asserted the cycle `an` returns to digit 0.

## Operation
- State:
  - `pre`: prescaler, 0..DWELL-1.
  - `dig`: current digit index, 0..NDIGITS-1.
  - `fcnt`: frame counter, 0..BLINK_FRAMES-1.
  - `bph`: blink phase bit.
  - Active image registers.
  - Pending image registers and `pending` flag.
- Prescaler:
  - `pre` increments every cycle.
  - At `pre==DWELL-1`, `pre` wraps to 0 and `dig` advances.
  - `dig` wraps from NDIGITS-1 to 0.
- Frame boundary: the cycle with `pre==DWELL-1` and `dig==NDIGITS-1`. At a boundary:
  - If `pending`, copy the pending image to the active image and clear `pending`.
  - `fcnt` increments. At BLINK_FRAMES-1 it wraps to 0 and `bph` toggles.
- Load:
  - `load` writes the pending buffer and sets `pending`.
  - A second `load` before the boundary overwrites the pending buffer; the last write wins.
  - `load` in a boundary cycle bypasses the buffer: the new inputs commit straight to the active image and `pending` stays 0.
  - `load` is ignored while `reset` is high.
- Decode:
  - The shared `ssdec` takes `in` = active nibble [dig].
  - Its `enable` = `en_mask[dig] & ~(bph & blink_mask[dig])`.
  - A disabled digit gives `seg`=0 while `an` still selects it, so dwell time stays uniform.
- Outputs:
  - Next cycle, `seg` takes the decoder output and `an` takes `1<<dig`.
  - `frame_start` is registered: it is 1 in the cycle `an` first equals `1`.
- Reset values:
  - `pre`=0, `dig`=0, `fcnt`=0, `bph`=0.
  - Active and pending images all-zero (masks 0, so every digit is blank).
  - `pending`=0, `seg`=0, `an`=0, `frame_start`=0.
- Reset asserted mid-frame or mid-load discards all state immediately, including any unloaded pending image.

## Timing
- Output latency: `seg` and `an` lag the `dig`/`pre` state by one cycle.
- Startup: the first cycle after reset deassertion shows `an`=`1` with `frame_start`=1.
- Each digit's `an` is high for exactly DWELL consecutive cycles, and one frame lasts NDIGITS×DWELL cycles.
- Load to display:
  - A loaded image appears on `seg` starting the cycle `frame_start` pulses after the boundary that commits it.
  - Worst case is NDIGITS×DWELL+1 cycles after `load`.
- `pending` rises the cycle after `load`, and falls the cycle after the committing boundary.
- Blink half-period is BLINK_FRAMES×NDIGITS×DWELL cycles.
- `an` is never multi-hot. Outside reset it is exactly one-hot.

## Structure
- Shared package `ssdisp_pkg`:
  - Constants `SEG_BLANK` (7'b0000000) and the default values of `DWELL` and `BLINK_FRAMES`.
  - Typedef `nibble_t` (logic [3:0]).
- Sub-module: exactly one `ssdec` instance, shared by all digits.
- Everything else stays in this module:
  - Prescaler, digit counter and frame/blink counter.
  - Double-buffer registers and output registers.

## Test plan
- Reset/startup, with NDIGITS=4, DWELL=4: hold `reset` 3 cycles, then release → `seg`=0 and `an`=0 during reset; first cycle after release `an`=4'b0001 with `frame_start`=1; `an` steps 0001→0010→0100→1000 every 4 cycles.
- Basic load: `load` with `value`=16'h3210, `en_mask`=4'hF mid-frame → `pending`=1 until the boundary; the next frame shows `seg` 0111111, 0000110, 1011011, 1001111 on digits 0..3; `pending`=0.
- Double load and bypass:
  - Two loads before a boundary (16'h1111, then 16'hABCD) → only ABCD is ever displayed.
  - A load exactly on a boundary cycle → it displays in the very next frame with `pending` never 1.
- Blank and blink, with BLINK_FRAMES=2: `en_mask`=4'b1011 and `blink_mask`=4'b0001 → digit 2 always `seg`=0 while still selected for 4 cycles; digit 0 alternates visible/blank every 2 frames.
- Reset mid-operation: assert `reset` during digit 2 with `pending`=1 → all outputs return to reset values immediately; after release all digits are blank and `pending`=0.

Source files
------------

// File: rtl/ssdisp_pkg.sv
// ssdisp_pkg
// Shared constants and types for the seven-segment scan controller.
//   SEG_BLANK            : segment pattern for a dark digit (gfedcba).
//   DWELL_DEFAULT        : default clock cycles each digit is held.
//   BLINK_FRAMES_DEFAULT : default full frames per blink half-period.
//   nibble_t             : one hex digit.
package ssdisp_pkg;

    localparam logic [6:0] SEG_BLANK            = 7'b0000000;
    localparam int         DWELL_DEFAULT        = 100;
    localparam int         BLINK_FRAMES_DEFAULT = 25;

    typedef logic [3:0] nibble_t;

endpackage

// File: rtl/ssdisp_scan_ssdec.sv
// ssdec
// Combinational hex-to-seven-segment decoder, common-cathode (1 = segment lit).
// Ports:
//   in     : hex nibble to display.
//   enable : 0 forces a blank digit.
//   seg    : segment pattern, bit order gfedcba.
module ssdec
    import ssdisp_pkg::*;
(
    input  nibble_t    in,
    input  logic       enable,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (enable) begin
            case (in)
                4'h0: seg = 7'b0111111;
                4'h1: seg = 7'b0000110;
                4'h2: seg = 7'b1011011;
                4'h3: seg = 7'b1001111;
                4'h4: seg = 7'b1100110;
                4'h5: seg = 7'b1101101;
                4'h6: seg = 7'b1111101;
                4'h7: seg = 7'b0000111;
                4'h8: seg = 7'b1111111;
                4'h9: seg = 7'b1101111;
                4'hA: seg = 7'b1110111;
                4'hB: seg = 7'b1111100;
                4'hC: seg = 7'b0111001;
                4'hD: seg = 7'b1011110;
                4'hE: seg = 7'b1111001;
                4'hF: seg = 7'b1110001;
            endcase
        end
    end

endmodule

// File: rtl/ssdisp_scan.sv
// ssdisp_scan
// Time-multiplexed scan controller: one shared ssdec drives NDIGITS
// common-cathode digits, one digit per DWELL cycles. The display image is
// double-buffered and new images take effect only at frame boundaries.
// Ports:
//   hz100       : system clock.
//   reset       : asynchronous, active-high reset.
//   load        : one-cycle strobe capturing value/en_mask/blink_mask.
//   value       : nibble i is the glyph for digit i.
//   en_mask     : bit i = 1 shows digit i.
//   blink_mask  : bit i = 1 makes digit i blink.
//   seg         : registered segment drive (gfedcba).
//   an          : registered one-hot digit select.
//   pending     : a loaded image is waiting for the next frame boundary.
//   frame_start : registered pulse, high the cycle an returns to digit 0.
module ssdisp_scan
    import ssdisp_pkg::*;
#(
    parameter int NDIGITS      = 8,
    parameter int DWELL        = DWELL_DEFAULT,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
) (
    input  logic                 hz100,
    input  logic                 reset,
    input  logic                 load,
    input  logic [4*NDIGITS-1:0] value,
    input  logic [NDIGITS-1:0]   en_mask,
    input  logic [NDIGITS-1:0]   blink_mask,
    output logic [6:0]           seg,
    output logic [NDIGITS-1:0]   an,
    output logic                 pending,
    output logic                 frame_start
);

    localparam int PW = $clog2(DWELL);
    localparam int DW = $clog2(NDIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]        pre;
    logic [DW-1:0]        dig;
    logic [FW-1:0]        fcnt;
    logic                 bph;

    logic [4*NDIGITS-1:0] act_val;
    logic [NDIGITS-1:0]   act_en;
    logic [NDIGITS-1:0]   act_bl;
    logic [4*NDIGITS-1:0] pnd_val;
    logic [NDIGITS-1:0]   pnd_en;
    logic [NDIGITS-1:0]   pnd_bl;

    logic                 dig_end;
    logic                 boundary;
    nibble_t              dec_in;
    logic                 dec_en;
    logic [6:0]           dec_seg;

    assign dig_end  = (pre == PW'(DWELL - 1));
    assign boundary = dig_end && (dig == DW'(NDIGITS - 1));

    assign dec_in = act_val[{dig, 2'b00} +: 4];
    assign dec_en = act_en[dig] & ~(bph & act_bl[dig]);

    ssdec u_ssdec (
        .in     (dec_in),
        .enable (dec_en),
        .seg    (dec_seg)
    );

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            pre         <= '0;
            dig         <= '0;
            fcnt        <= '0;
            bph         <= 1'b0;
            act_val     <= '0;
            act_en      <= '0;
            act_bl      <= '0;
            pnd_val     <= '0;
            pnd_en      <= '0;
            pnd_bl      <= '0;
            pending     <= 1'b0;
            seg         <= SEG_BLANK;
            an          <= '0;
            frame_start <= 1'b0;
        end else begin
            pre <= dig_end ? '0 : pre + PW'(1);
            if (dig_end) begin
                dig <= (dig == DW'(NDIGITS - 1)) ? '0 : dig + DW'(1);
            end

            if (boundary) begin
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt <= '0;
                    bph  <= ~bph;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end

            // A load landing on the boundary goes straight to the active
            // image; it is newer than anything still sitting in pending.
            if (load && boundary) begin
                act_val <= value;
                act_en  <= en_mask;
                act_bl  <= blink_mask;
                pending <= 1'b0;
            end else if (boundary && pending) begin
                act_val <= pnd_val;
                act_en  <= pnd_en;
                act_bl  <= pnd_bl;
                pending <= 1'b0;
            end else if (load) begin
                pnd_val <= value;
                pnd_en  <= en_mask;
                pnd_bl  <= blink_mask;
                pending <= 1'b1;
            end

            seg         <= dec_seg;
            an          <= NDIGITS'(1) << dig;
            frame_start <= (pre == '0) && (dig == '0);
        end
    end

endmodule

// File: tb/tb_ssdisp_scan.sv
module tb_ssdisp_scan;

    localparam int N     = 4;
    localparam int D     = 4;
    localparam int BF    = 2;
    localparam int FRAME = N * D;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        hz100 = 1'b0;
    logic        reset = 1'b1;
    logic        load  = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  en_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        pending;
    logic        frame_start;

    int vectors = 0;
    int miscompares = 0;

    // reference model: tick count since reset release plus image bookkeeping
    int          kk = 0;
    logic [15:0] m_val = '0, p_val = '0;
    logic [3:0]  m_en = '0, m_bl = '0, p_en = '0, p_bl = '0;
    logic        m_pend = 1'b0;
    logic [6:0]  exp_seg = '0;
    logic [3:0]  exp_an = '0;
    logic        exp_fs = 1'b0;
    logic        exp_pend = 1'b0;

    ssdisp_scan #(.NDIGITS(N), .DWELL(D), .BLINK_FRAMES(BF)) dut (
        .hz100       (hz100),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .en_mask     (en_mask),
        .blink_mask  (blink_mask),
        .seg         (seg),
        .an          (an),
        .pending     (pending),
        .frame_start (frame_start)
    );

    always #5 hz100 = ~hz100;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; predict outputs from the state that was current
    // before the edge, then apply this edge's load/boundary effects.
    task automatic step();
        int   digit, frame;
        logic ph, bnd;
        @(posedge hz100);
        if (reset) begin
            m_val = '0; m_en = '0; m_bl = '0;
            p_val = '0; p_en = '0; p_bl = '0;
            m_pend = 1'b0;
            exp_seg = '0; exp_an = '0; exp_fs = 1'b0;
            kk = 0;
        end else begin
            digit   = (kk / D) % N;
            frame   = kk / FRAME;
            ph      = ((frame / BF) % 2) == 1;
            bnd     = (kk % FRAME) == FRAME - 1;
            exp_an  = 4'(1 << digit);
            exp_fs  = (kk % FRAME) == 0;
            exp_seg = (m_en[digit] && !(ph && m_bl[digit])) ? GLYPH[m_val[digit*4 +: 4]] : 7'h00;
            if (load) begin
                if (bnd) begin
                    m_val = value; m_en = en_mask; m_bl = blink_mask; m_pend = 1'b0;
                end else begin
                    p_val = value; p_en = en_mask; p_bl = blink_mask; m_pend = 1'b1;
                end
            end else if (bnd && m_pend) begin
                m_val = p_val; m_en = p_en; m_bl = p_bl; m_pend = 1'b0;
            end
            kk++;
        end
        exp_pend = m_pend;
        #1;
    endtask

    // Step without checking until the next edge falls on the given frame phase.
    task automatic run_to(input int phase);
        for (int i = 0; i < FRAME && (kk % FRAME) != phase; i++) step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            load = (i == 1);
            value = 16'hFFFF; en_mask = 4'hF;
            step();
            vectors++;
            if ({seg, an, frame_start, pending} !== 13'b0) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d: got seg=%b an=%b fs=%b pend=%b expected all zero",
                         i, seg, an, frame_start, pending);
            end
        end
        load = 1'b0; value = '0; en_mask = '0;
        reset = 1'b0;
    endtask

    task automatic test_startup();
        for (int i = 0; i < FRAME + 4; i++) begin
            step();
            if (i == 0) begin
                vectors++;
                if (an !== 4'b0001 || frame_start !== 1'b1) begin
                    miscompares++;
                    $display("FAIL startup_first: got an=%b fs=%b expected an=0001 fs=1", an, frame_start);
                end
            end
            vectors++;
            if ({seg, an, frame_start, pending} !== {exp_seg, exp_an, exp_fs, exp_pend} || !$onehot(an)) begin
                miscompares++;
                $display("FAIL startup k=%0d: got seg=%b an=%b fs=%b pend=%b expected seg=%b an=%b fs=%b pend=%b",
                         kk, seg, an, frame_start, pending, exp_seg, exp_an, exp_fs, exp_pend);
            end
        end
    endtask

    task automatic test_basic_load();
        logic [6:0] want [4];
        want[0] = 7'b0111111; want[1] = 7'b0000110; want[2] = 7'b1011011; want[3] = 7'b1001111;
        run_to(5);
        value = 16'h3210; en_mask = 4'hF; blink_mask = 4'h0; load = 1'b1;
        step();
        load = 1'b0;
        vectors++;
        if (pending !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_pending_rise: got %b expected 1", pending);
        end
        run_to(0);
        vectors++;
        if (pending !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_pending_fall: got %b expected 0", pending);
        end
        for (int i = 0; i < FRAME; i++) begin
            step();
            vectors++;
            if ({seg, an, frame_start, pending} !== {exp_seg, exp_an, exp_fs, exp_pend} || seg !== want[i / D]) begin
                miscompares++;
                $display("FAIL basic_frame i=%0d: got seg=%b an=%b fs=%b pend=%b expected seg=%b(%b) an=%b fs=%b pend=%b",
                         i, seg, an, frame_start, pending, exp_seg, want[i / D], exp_an, exp_fs, exp_pend);
            end
        end
    endtask

    task automatic test_double_load();
        logic [15:0] last;
        last = 16'hABCD;
        run_to(3);
        value = 16'h1111; en_mask = 4'hF; load = 1'b1;
        step();
        load = 1'b0;
        step();
        value = last; load = 1'b1;
        step();
        load = 1'b0;
        run_to(0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            vectors++;
            if ({seg, an, frame_start, pending} !== {exp_seg, exp_an, exp_fs, exp_pend}
                || seg !== GLYPH[last[((i / D) % N) * 4 +: 4]]) begin
                miscompares++;
                $display("FAIL double_load i=%0d: got seg=%b an=%b fs=%b pend=%b expected seg=%b an=%b fs=%b pend=%b",
                         i, seg, an, frame_start, pending, exp_seg, exp_an, exp_fs, exp_pend);
            end
        end
    endtask

    task automatic test_bypass();
        logic [15:0] v;
        v = 16'h8E5C;
        run_to(FRAME - 1);
        value = v; en_mask = 4'hF; load = 1'b1;
        step();
        load = 1'b0;
        vectors++;
        if (pending !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_pending: got %b expected 0", pending);
        end
        for (int i = 0; i < FRAME; i++) begin
            step();
            vectors++;
            if ({seg, an, frame_start, pending} !== {exp_seg, exp_an, exp_fs, exp_pend}
                || seg !== GLYPH[v[(i / D) * 4 +: 4]] || pending !== 1'b0) begin
                miscompares++;
                $display("FAIL bypass_frame i=%0d: got seg=%b an=%b fs=%b pend=%b expected seg=%b an=%b fs=%b pend=0",
                         i, seg, an, frame_start, pending, GLYPH[v[(i / D) * 4 +: 4]], exp_an, exp_fs);
            end
        end
    endtask

    task automatic test_blink();
        int lit0, dark0;
        lit0 = 0; dark0 = 0;
        run_to(7);
        value = 16'h7654; en_mask = 4'b1011; blink_mask = 4'b0001; load = 1'b1;
        step();
        load = 1'b0;
        run_to(0);
        for (int i = 0; i < 4 * BF * FRAME; i++) begin
            step();
            vectors++;
            if ({seg, an, frame_start, pending} !== {exp_seg, exp_an, exp_fs, exp_pend}) begin
                miscompares++;
                $display("FAIL blink i=%0d: got seg=%b an=%b fs=%b pend=%b expected seg=%b an=%b fs=%b pend=%b",
                         i, seg, an, frame_start, pending, exp_seg, exp_an, exp_fs, exp_pend);
            end
            if (an === 4'b0100) begin
                vectors++;
                if (seg !== 7'b0) begin
                    miscompares++;
                    $display("FAIL blink_blank_digit2 i=%0d: got seg=%b expected 0000000", i, seg);
                end
            end
            if (an === 4'b0001) begin
                if (seg === GLYPH[4]) lit0++;
                else if (seg === 7'b0) dark0++;
            end
        end
        vectors++;
        if (lit0 != 2 * BF * D || dark0 != 2 * BF * D) begin
            miscompares++;
            $display("FAIL blink_digit0_duty: got lit=%0d dark=%0d expected %0d each", lit0, dark0, 2 * BF * D);
        end
        blink_mask = 4'h0;
    endtask

    task automatic test_reset_mid();
        run_to(2);
        value = 16'hFEDC; en_mask = 4'hF; load = 1'b1;
        step();
        load = 1'b0;
        run_to(8);
        step();
        step();
        vectors++;
        if (an !== 4'b0100 || pending !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_setup: got an=%b pend=%b expected an=0100 pend=1", an, pending);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({seg, an, frame_start, pending} !== 13'b0) begin
            miscompares++;
            $display("FAIL reset_mid_async: got seg=%b an=%b fs=%b pend=%b expected all zero",
                     seg, an, frame_start, pending);
        end
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            vectors++;
            if ({seg, an, frame_start, pending} !== {exp_seg, exp_an, exp_fs, exp_pend}
                || seg !== 7'b0 || pending !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_after i=%0d: got seg=%b an=%b fs=%b pend=%b expected seg=0000000 an=%b fs=%b pend=0",
                         i, seg, an, frame_start, pending, exp_an, exp_fs);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            load       = ($urandom_range(0, 7) == 0);
            value      = 16'($urandom);
            en_mask    = 4'($urandom);
            blink_mask = 4'($urandom);
            step();
            vectors++;
            if ({seg, an, frame_start, pending} !== {exp_seg, exp_an, exp_fs, exp_pend} || !$onehot(an)) begin
                miscompares++;
                $display("FAIL random i=%0d: got seg=%b an=%b fs=%b pend=%b expected seg=%b an=%b fs=%b pend=%b",
                         i, seg, an, frame_start, pending, exp_seg, exp_an, exp_fs, exp_pend);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_basic_load();
        test_double_load();
        test_bypass();
        test_blink();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
